// File: rtl/dds_voice_scheduler_pkg.sv
// Shared constants and types for the DDS voice scheduler.
// Voice count and widths are configured here; all scheduler files import this package.
package dds_pkg;

  localparam int NUM_VOICES  = 4;
  localparam int PHASE_W     = 32;
  localparam int NOTE_W      = 8;
  localparam int VOICE_IDX_W = $clog2(NUM_VOICES);
  localparam int MIX_W       = 8 + VOICE_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COMMIT = 2'd2
  } alloc_state_e;

  typedef struct packed {
    logic                   active;
    logic [NOTE_W-1:0]      note;
    logic [PHASE_W-1:0]     adder;
    logic [PHASE_W-1:0]     phase;
    logic [VOICE_IDX_W-1:0] age;
  } voice_t;

endpackage

// File: rtl/dds_voice_scheduler_alloc.sv
// Voice allocator: accepts commands, scans voices one per cycle, then commits a write.
// Owns the LRU ages (0 = most recently allocated, NUM_VOICES-1 = oldest).
module dds_voice_alloc
  import dds_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic                   i_cmd_on,
  input  logic [NOTE_W-1:0]      i_cmd_note,
  input  logic [PHASE_W-1:0]     i_cmd_adder,
  input  logic [NUM_VOICES-1:0]  i_voice_active,
  input  logic [NOTE_W-1:0]      i_voice_note [NUM_VOICES],
  output logic                   o_cmd_ready,
  output logic                   o_wr_en,
  output logic                   o_wr_on,
  output logic [VOICE_IDX_W-1:0] o_wr_idx,
  output logic [NOTE_W-1:0]      o_wr_note,
  output logic [PHASE_W-1:0]     o_wr_adder,
  output alloc_state_e           o_state
);

  localparam logic [VOICE_IDX_W-1:0] IDX_LAST = VOICE_IDX_W'(NUM_VOICES - 1);

  alloc_state_e           r_state, w_state_nxt;
  logic                   r_on;
  logic [NOTE_W-1:0]      r_note;
  logic [PHASE_W-1:0]     r_adder;
  logic [VOICE_IDX_W-1:0] r_idx;
  logic                   r_match_vld, r_free_vld;
  logic [VOICE_IDX_W-1:0] r_match_idx, r_free_idx, r_oldest_idx;
  logic [VOICE_IDX_W-1:0] r_age [NUM_VOICES];
  logic [VOICE_IDX_W-1:0] w_target;

  // Handshake: a command transfers on a rising edge where i_cmd_valid && o_cmd_ready;
  // ready is only offered in IDLE and the command fields are latched at that edge only.
  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = !i_reset;
        if (i_cmd_valid) w_state_nxt = SEARCH;
      end
      SEARCH:  if (r_idx == IDX_LAST) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_target   = r_match_vld ? r_match_idx : (r_free_vld ? r_free_idx : r_oldest_idx);
  assign o_wr_en    = (r_state == COMMIT) && (r_on || r_match_vld);
  assign o_wr_on    = r_on;
  assign o_wr_idx   = r_on ? w_target : r_match_idx;
  assign o_wr_note  = r_note;
  assign o_wr_adder = r_adder;
  assign o_state    = r_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_on         <= 1'b0;
      r_note       <= '0;
      r_adder      <= '0;
      r_idx        <= '0;
      r_match_vld  <= 1'b0;
      r_free_vld   <= 1'b0;
      r_match_idx  <= '0;
      r_free_idx   <= '0;
      r_oldest_idx <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= VOICE_IDX_W'(i);
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_on    <= i_cmd_on;
            r_note  <= i_cmd_note;
            r_adder <= i_cmd_adder;
          end
          r_idx        <= '0;
          r_match_vld  <= 1'b0;
          r_free_vld   <= 1'b0;
          r_oldest_idx <= '0;
        end
        SEARCH: begin
          if (!r_match_vld && i_voice_active[r_idx] && (i_voice_note[r_idx] == r_note)) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!r_free_vld && !i_voice_active[r_idx]) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (r_age[r_idx] == IDX_LAST) r_oldest_idx <= r_idx;
          r_idx <= r_idx + 1'b1;
        end
        COMMIT: begin
          // Ages stay a permutation: everything younger than the target moves back one.
          if (r_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (VOICE_IDX_W'(i) == w_target) r_age[i] <= '0;
              else if (r_age[i] < r_age[w_target]) r_age[i] <= r_age[i] + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dds_voice_scheduler.sv
// Time-multiplexed DDS phase accumulator shared by NUM_VOICES voices, one slot per clock.
// Optional sawtooth frame mix output enabled by defining DDS_VOICE_MIX_EN.
module dds_voice_scheduler
  import dds_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_on,
  input  logic [NOTE_W-1:0]      i_cmd_note,
  input  logic [PHASE_W-1:0]     i_cmd_adder,
  output logic [VOICE_IDX_W-1:0] o_slot_idx,
  output logic [PHASE_W-1:0]     o_slot_phase,
  output logic                   o_slot_active,
  output logic                   o_frame_start,
`ifdef DDS_VOICE_MIX_EN
  output logic [MIX_W-1:0]       o_mix_out,
`endif
  output alloc_state_e           o_alloc_state
);

  logic [VOICE_IDX_W-1:0] r_slot;
  logic [NUM_VOICES-1:0]  r_active;
  logic [NOTE_W-1:0]      r_note  [NUM_VOICES];
  logic [PHASE_W-1:0]     r_adder [NUM_VOICES];
  logic [PHASE_W-1:0]     r_phase [NUM_VOICES];

  logic [VOICE_IDX_W-1:0] r_slot_idx;
  logic [PHASE_W-1:0]     r_slot_phase;
  logic                   r_slot_active;
  logic                   r_frame_start;

  logic                   w_wr_en, w_wr_on;
  logic [VOICE_IDX_W-1:0] w_wr_idx;
  logic [NOTE_W-1:0]      w_wr_note;
  logic [PHASE_W-1:0]     w_wr_adder;
  logic [NUM_VOICES-1:0]  w_active_nxt;
  logic [PHASE_W-1:0]     w_phase_nxt [NUM_VOICES];

  dds_voice_alloc u_alloc (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd_on       (i_cmd_on),
    .i_cmd_note     (i_cmd_note),
    .i_cmd_adder    (i_cmd_adder),
    .i_voice_active (r_active),
    .i_voice_note   (r_note),
    .o_cmd_ready    (o_cmd_ready),
    .o_wr_en        (w_wr_en),
    .o_wr_on        (w_wr_on),
    .o_wr_idx       (w_wr_idx),
    .o_wr_note      (w_wr_note),
    .o_wr_adder     (w_wr_adder),
    .o_state        (o_alloc_state)
  );

  // A commit to the voice in the current slot overrides that slot's accumulate.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_phase_nxt[i]  = r_phase[i];
      w_active_nxt[i] = r_active[i];
      if (w_wr_en && (w_wr_idx == VOICE_IDX_W'(i))) begin
        w_phase_nxt[i]  = w_wr_on ? '0 : r_phase[i];
        w_active_nxt[i] = w_wr_on;
      end else if ((r_slot == VOICE_IDX_W'(i)) && r_active[i]) begin
        w_phase_nxt[i] = r_phase[i] + r_adder[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot        <= '0;
      r_active      <= '0;
      r_slot_idx    <= '0;
      r_slot_phase  <= '0;
      r_slot_active <= 1'b0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i]  <= '0;
        r_adder[i] <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      r_slot   <= r_slot + 1'b1;
      r_active <= w_active_nxt;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= w_phase_nxt[i];
        if (w_wr_en && w_wr_on && (w_wr_idx == VOICE_IDX_W'(i))) begin
          r_note[i]  <= w_wr_note;
          r_adder[i] <= w_wr_adder;
        end
      end
      r_slot_idx    <= r_slot;
      r_slot_phase  <= w_phase_nxt[r_slot];
      r_slot_active <= w_active_nxt[r_slot];
      r_frame_start <= (r_slot == '0);
    end
  end

  assign o_slot_idx    = r_slot_idx;
  assign o_slot_phase  = r_slot_phase;
  assign o_slot_active = r_slot_active;
  assign o_frame_start = r_frame_start;

`ifdef DDS_VOICE_MIX_EN
  logic [MIX_W-1:0] r_mix_acc, r_mix_out, w_mix_top;

  // Accumulates from the registered slot outputs so the total lands with the next frame start.
  assign w_mix_top = r_slot_active ? MIX_W'(r_slot_phase[PHASE_W-1 -: 8]) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mix_acc <= '0;
      r_mix_out <= '0;
    end else begin
      r_mix_acc <= (r_slot_idx == '0) ? w_mix_top : r_mix_acc + w_mix_top;
      if (r_slot_idx == VOICE_IDX_W'(NUM_VOICES - 1)) r_mix_out <= r_mix_acc + w_mix_top;
    end
  end

  assign o_mix_out = r_mix_out;
`endif

endmodule
